// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: glyph width, lit-high glyph constants and digit code type.
// Glyph bit order is {a,b,c,d,e,f,g}, so bit 6 is segment a.
package seg7_pkg;

   localparam int SEG_W = 7;

   typedef logic [3:0]       digit_t;
   typedef logic [SEG_W-1:0] glyph_t;

   localparam glyph_t GLYPH_0     = 7'h7E;
   localparam glyph_t GLYPH_1     = 7'h30;
   localparam glyph_t GLYPH_2     = 7'h6D;
   localparam glyph_t GLYPH_3     = 7'h79;
   localparam glyph_t GLYPH_4     = 7'h33;
   localparam glyph_t GLYPH_5     = 7'h5B;
   localparam glyph_t GLYPH_6     = 7'h5F;
   localparam glyph_t GLYPH_7     = 7'h70;
   localparam glyph_t GLYPH_8     = 7'h7F;
   localparam glyph_t GLYPH_9     = 7'h7B;
   localparam glyph_t GLYPH_A     = 7'h77;
   localparam glyph_t GLYPH_B     = 7'h1F;
   localparam glyph_t GLYPH_C     = 7'h4E;
   localparam glyph_t GLYPH_D     = 7'h3D;
   localparam glyph_t GLYPH_E     = 7'h4F;
   localparam glyph_t GLYPH_F     = 7'h47;
   localparam glyph_t GLYPH_BLANK = 7'h00;

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display-side bundle: digit data and controls in, pin-level drive and frame pulse out.
// The slave modport is the scan driver; the master is whoever supplies the digits.
interface seg_scan_driver_if
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 8
);
   logic                    enable;
   logic [4*NUM_DIGITS-1:0] digits;
   logic [NUM_DIGITS-1:0]   blink_mask;
   logic [NUM_DIGITS-1:0]   dp_mask;
   logic [3:0]              brightness;
   logic [NUM_DIGITS-1:0]   an;
   glyph_t                  seg;
   logic                    dp;
   logic                    frame_tick;

   modport master (
      output enable, digits, blink_mask, dp_mask, brightness,
      input  an, seg, dp, frame_tick
   );

   modport slave (
      input  enable, digits, blink_mask, dp_mask, brightness,
      output an, seg, dp, frame_tick
   );
endinterface

// File: rtl/seg7_decode.sv
// Combinational nibble to lit-high glyph; codes 10-15 show hex letters only when HEX_EN is set.
module seg7_decode
   import seg7_pkg::*;
#(
   parameter bit HEX_EN = 1'b0
)(
   input  digit_t code_i,
   output glyph_t glyph_o
);

   always_comb begin
      glyph_o = GLYPH_BLANK;
      case (code_i)
         4'h0: glyph_o = GLYPH_0;
         4'h1: glyph_o = GLYPH_1;
         4'h2: glyph_o = GLYPH_2;
         4'h3: glyph_o = GLYPH_3;
         4'h4: glyph_o = GLYPH_4;
         4'h5: glyph_o = GLYPH_5;
         4'h6: glyph_o = GLYPH_6;
         4'h7: glyph_o = GLYPH_7;
         4'h8: glyph_o = GLYPH_8;
         4'h9: glyph_o = GLYPH_9;
         4'hA: glyph_o = HEX_EN ? GLYPH_A : GLYPH_BLANK;
         4'hB: glyph_o = HEX_EN ? GLYPH_B : GLYPH_BLANK;
         4'hC: glyph_o = HEX_EN ? GLYPH_C : GLYPH_BLANK;
         4'hD: glyph_o = HEX_EN ? GLYPH_D : GLYPH_BLANK;
         4'hE: glyph_o = HEX_EN ? GLYPH_E : GLYPH_BLANK;
         4'hF: glyph_o = HEX_EN ? GLYPH_F : GLYPH_BLANK;
         default: glyph_o = GLYPH_BLANK;
      endcase
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with per-digit blink, decimal points
// and PWM brightness; every pin is driven straight from a register.
module seg_scan_driver
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS     = 8,
   parameter int SLOT_LOG2      = 10,
   parameter int BLINK_FRAMES   = 64,
   parameter bit HEX_EN         = 1'b0,
   parameter bit AN_ACTIVE_LOW  = 1'b1,
   parameter bit SEG_ACTIVE_LOW = 1'b1
)(
   input  logic             clk,
   input  logic             rst_n,
   seg_scan_driver_if.slave disp
);

   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [FRM_W-1:0]      FRM_LAST = FRM_W'(BLINK_FRAMES - 1);
   localparam logic [NUM_DIGITS-1:0] AN_IDLE  = AN_ACTIVE_LOW ? '1 : '0;
   localparam glyph_t                SEG_IDLE = SEG_ACTIVE_LOW ? '1 : '0;
   localparam logic                  DP_IDLE  = SEG_ACTIVE_LOW;

   logic [SLOT_LOG2-1:0]  presc_q, presc_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [FRM_W-1:0]      frm_q, frm_d;
   logic                  phase_q, phase_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   glyph_t                seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic                  tick_q, tick_d;

   digit_t                digit_arr [NUM_DIGITS];
   digit_t                cur_code;
   glyph_t                cur_glyph;
   glyph_t                seg_lit;
   logic [NUM_DIGITS-1:0] an_lit;
   logic                  slot_end, last_digit, blanked, anode_on, dp_lit;

   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digit_arr[gi] = disp.digits[4*gi +: 4];
   end

   assign cur_code = digit_arr[idx_q];

   seg7_decode #(
      .HEX_EN (HEX_EN)
   ) u_decode (
      .code_i  (cur_code),
      .glyph_o (cur_glyph)
   );

   always_comb begin
      slot_end   = &presc_q;
      last_digit = (idx_q == IDX_LAST);

      presc_d = presc_q + SLOT_LOG2'(1);
      idx_d   = idx_q;
      frm_d   = frm_q;
      phase_d = phase_q;
      if (slot_end) begin
         idx_d = last_digit ? '0 : idx_q + IDX_W'(1);
         if (last_digit) begin
            if (frm_q == FRM_LAST) begin
               frm_d   = '0;
               phase_d = ~phase_q;
            end else begin
               frm_d = frm_q + FRM_W'(1);
            end
         end
      end

      // Prescaler value 0 is kept dark so the previous digit's pattern never ghosts onto the next anode.
      blanked  = disp.blink_mask[idx_q] & phase_q;
      anode_on = disp.enable
               && (presc_q[SLOT_LOG2-1 -: 4] <= disp.brightness)
               && (presc_q != '0);

      an_lit        = '0;
      an_lit[idx_q] = anode_on;
      seg_lit       = blanked ? GLYPH_BLANK : cur_glyph;
      dp_lit        = disp.dp_mask[idx_q] & ~blanked;

      an_d   = AN_ACTIVE_LOW  ? ~an_lit  : an_lit;
      seg_d  = SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
      dp_d   = SEG_ACTIVE_LOW ? ~dp_lit  : dp_lit;
      tick_d = slot_end & last_digit;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc_q <= '0;
         idx_q   <= '0;
         frm_q   <= '0;
         phase_q <= 1'b0;
         an_q    <= AN_IDLE;
         seg_q   <= SEG_IDLE;
         dp_q    <= DP_IDLE;
         tick_q  <= 1'b0;
      end else begin
         presc_q <= presc_d;
         idx_q   <= idx_d;
         frm_q   <= frm_d;
         phase_q <= phase_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         tick_q  <= tick_d;
      end
   end

   assign disp.an         = an_q;
   assign disp.seg        = seg_q;
   assign disp.dp         = dp_q;
   assign disp.frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: two instances (hex glyphs off/on) share one stimulus stream and are
// compared every cycle against a cycle-count model of the scan, blink and PWM rules.
module tb_seg_scan_driver;

   localparam int N    = 4;
   localparam int SL   = 4;
   localparam int BF   = 2;
   localparam int SLOT = 1 << SL;
   localparam int FRM  = SLOT * N;

   localparam logic [6:0] GLYPHS [16] = '{
      7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
      7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
   };

   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;
   int   t_model  = 0;

   always #5 clk = ~clk;

   seg_scan_driver_if #(.NUM_DIGITS(N)) if_h ();
   seg_scan_driver_if #(.NUM_DIGITS(N)) if_x ();

   assign if_x.enable     = if_h.enable;
   assign if_x.digits     = if_h.digits;
   assign if_x.blink_mask = if_h.blink_mask;
   assign if_x.dp_mask    = if_h.dp_mask;
   assign if_x.brightness = if_h.brightness;

   seg_scan_driver #(
      .NUM_DIGITS(N), .SLOT_LOG2(SL), .BLINK_FRAMES(BF),
      .HEX_EN(1'b0), .AN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
   ) dut_h (
      .clk   (clk),
      .rst_n (rst_n),
      .disp  (if_h)
   );

   seg_scan_driver #(
      .NUM_DIGITS(N), .SLOT_LOG2(SL), .BLINK_FRAMES(BF),
      .HEX_EN(1'b1), .AN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
   ) dut_x (
      .clk   (clk),
      .rst_n (rst_n),
      .disp  (if_x)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h (model cycle %0d, time %0t)", tag, got, exp, t_model, $time);
      end
   endtask

   function automatic logic [6:0] ref_glyph(input logic [3:0] code, input bit hex);
      if (code < 4'd10 || hex) return GLYPHS[code];
      return 7'h00;
   endfunction

   // One clock: predict the registered pins from the cycles elapsed since reset and the live inputs.
   task automatic step();
      logic [N-1:0] e_an;
      logic [6:0]   e_seg_h, e_seg_x;
      logic         e_dp, e_tick;
      @(posedge clk);
      if (!rst_n) begin
         e_an    = '1;
         e_seg_h = 7'h7F;
         e_seg_x = 7'h7F;
         e_dp    = 1'b1;
         e_tick  = 1'b0;
         t_model = 0;
      end else begin
         int  p, idx, frame;
         bit  phase, blank, lit;
         logic [3:0] code;
         p     = t_model % SLOT;
         idx   = (t_model / SLOT) % N;
         frame = t_model / FRM;
         phase = ((frame / BF) % 2) == 1;
         blank = if_h.blink_mask[idx] && phase;
         lit   = if_h.enable && ((p >> (SL - 4)) <= int'(if_h.brightness)) && (p != 0);
         code  = if_h.digits[4*idx +: 4];
         e_an    = lit ? ~(N'(1) << idx) : '1;
         e_seg_h = blank ? 7'h7F : ~ref_glyph(code, 1'b0);
         e_seg_x = blank ? 7'h7F : ~ref_glyph(code, 1'b1);
         e_dp    = ~(if_h.dp_mask[idx] && !blank);
         e_tick  = (t_model % FRM) == (FRM - 1);
         t_model++;
      end
      #1;
      check_eq("an_h",   32'(if_h.an),         32'(e_an));
      check_eq("an_x",   32'(if_x.an),         32'(e_an));
      check_eq("seg_h",  32'(if_h.seg),        32'(e_seg_h));
      check_eq("seg_x",  32'(if_x.seg),        32'(e_seg_x));
      check_eq("dp_h",   32'(if_h.dp),         32'(e_dp));
      check_eq("dp_x",   32'(if_x.dp),         32'(e_dp));
      check_eq("tick_h", 32'(if_h.frame_tick), 32'(e_tick));
      check_eq("tick_x", 32'(if_x.frame_tick), 32'(e_tick));
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Advance until the model says the scan is on digit 2; bounded by one frame.
   task automatic goto_digit2();
      int guard;
      guard = 0;
      while (((t_model / SLOT) % N) != 2 && guard < FRM) begin
         step();
         guard++;
      end
      check_eq("reach_digit2", 32'((t_model / SLOT) % N), 32'd2);
   endtask

   task automatic report(input string name);
      $display("phase %-10s model_cycle=%0d checks=%0d failures=%0d", name, t_model, checks, failures);
   endtask

   initial begin
      rst_n           = 1'b0;
      if_h.enable     = 1'b1;
      if_h.digits     = 16'h1234;
      if_h.blink_mask = '0;
      if_h.dp_mask    = '0;
      if_h.brightness = 4'd15;

      run(3);
      report("reset");

      rst_n = 1'b1;
      run(2 * FRM);
      report("scan");

      if_h.blink_mask = 4'b0010;
      if_h.dp_mask    = 4'b0010;
      run(5 * FRM);
      report("blink");

      if_h.blink_mask = '0;
      if_h.brightness = 4'd0;
      run(FRM);
      if_h.brightness = 4'd7;
      run(FRM);
      report("brightness");

      if_h.brightness = 4'd15;
      if_h.digits     = 16'hF0CA;
      run(FRM);
      report("hex");

      goto_digit2();
      if_h.enable = 1'b0;
      run(20);
      if_h.enable = 1'b1;
      run(FRM);
      report("enable");

      goto_digit2();
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      run(FRM + 16);
      report("mid_reset");

      for (int i = 0; i < 1500; i++) begin
         if_h.digits     = 16'($urandom);
         if_h.blink_mask = 4'($urandom);
         if_h.dp_mask    = 4'($urandom);
         if_h.brightness = 4'($urandom);
         if_h.enable     = ($urandom_range(0, 7) != 0);
         rst_n           = ($urandom_range(0, 255) != 0);
         step();
      end
      rst_n = 1'b1;
      report("random");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
